// File: rtl/timer_pkg.sv
// Shared types and helpers for the MM:SS BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_FIVE = 4'd5;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] digit, input logic [3:0] max_digit);
    return (digit > max_digit) ? max_digit : digit;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One loadable down-counting BCD digit; wraps 0 -> max_i and flags a borrow.
module bcd_digit_down (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [3:0] max_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] digit_o,
  output logic       borrow_o
);

  logic [3:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load_i)
      digit_d = load_val_i;
    else if (en_i)
      digit_d = (digit_q == '0) ? max_i : digit_q - 4'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) digit_q <= '0;
    else       digit_q <= digit_d;
  end

  assign digit_o  = digit_q;
  assign borrow_o = en_i & (digit_q == '0);

endmodule

// File: rtl/countdown_timer_bcd.sv
// Loadable MM:SS BCD countdown timer with done pulse and sticky expired state.
// Optional `AUTO_RELOAD_EN: reload the last loaded value at 00:00 and keep running.
module countdown_timer_bcd
  import timer_pkg::*;
#(
  parameter int unsigned MAX_MIN_TENS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam logic [3:0] MT_MAX = 4'(MAX_MIN_TENS);

  state_e      state_q, state_d;
  logic        done_q, done_d;
  logic [15:0] count;
  logic [15:0] load_clamped;
  logic [15:0] dig_val;
  logic        dig_load;
  logic        tick_dec;
  logic        terminal;
  logic        reload_hit;
  logic [2:0]  borrow;
  logic        unused_borrow;

  assign load_clamped = {bcd_clamp(load_min[7:4], MT_MAX),  bcd_clamp(load_min[3:0], BCD_NINE),
                         bcd_clamp(load_sec[7:4], BCD_FIVE), bcd_clamp(load_sec[3:0], BCD_NINE)};

  // Decrement only when nothing of higher priority is asserted this cycle.
  assign tick_dec = tick_1hz & (state_q == ST_RUN) & ~load & ~stop;
  assign terminal = tick_dec & (count == 16'h0001);

`ifdef AUTO_RELOAD_EN
  logic [15:0] reload_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     reload_q <= '0;
    else if (load) reload_q <= load_clamped;
  end

  assign reload_hit = terminal & (reload_q != '0);
  assign dig_val    = load ? load_clamped : reload_q;
`else
  assign reload_hit = 1'b0;
  assign dig_val    = load_clamped;
`endif

  assign dig_load = load | reload_hit;

  bcd_digit_down u_sec_units (
    .clk_i(clk), .rst_i(reset), .en_i(tick_dec), .max_i(BCD_NINE),
    .load_i(dig_load), .load_val_i(dig_val[3:0]),
    .digit_o(count[3:0]), .borrow_o(borrow[0])
  );

  bcd_digit_down u_sec_tens (
    .clk_i(clk), .rst_i(reset), .en_i(borrow[0]), .max_i(BCD_FIVE),
    .load_i(dig_load), .load_val_i(dig_val[7:4]),
    .digit_o(count[7:4]), .borrow_o(borrow[1])
  );

  bcd_digit_down u_min_units (
    .clk_i(clk), .rst_i(reset), .en_i(borrow[1]), .max_i(BCD_NINE),
    .load_i(dig_load), .load_val_i(dig_val[11:8]),
    .digit_o(count[11:8]), .borrow_o(borrow[2])
  );

  // Counting stops at 00:00, so the top digit never actually borrows.
  bcd_digit_down u_min_tens (
    .clk_i(clk), .rst_i(reset), .en_i(borrow[2]), .max_i(MT_MAX),
    .load_i(dig_load), .load_val_i(dig_val[15:12]),
    .digit_o(count[15:12]), .borrow_o(unused_borrow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = terminal;
    if (load) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (!stop && start && count != '0) state_d = ST_RUN;
        ST_RUN:     if (stop) state_d = ST_PAUSE;
                    else if (terminal && !reload_hit) state_d = ST_EXPIRED;
        ST_PAUSE:   if (!stop && start) state_d = ST_RUN;
        ST_EXPIRED: state_d = ST_EXPIRED;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    min_bcd = count[15:8];
    sec_bcd = count[7:0];
    running = (state_q == ST_RUN);
    expired = (state_q == ST_EXPIRED);
    done    = done_q;
  end

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Scoreboard bench for countdown_timer_bcd; model tracks the count as total seconds.
module tb_countdown_timer_bcd;

  logic       clk = 1'b0;
  logic       reset, tick_1hz, load, start, stop;
  logic [7:0] load_min, load_sec, min_bcd, sec_bcd;
  logic       running, done, expired;

  always #5 clk = ~clk;

  countdown_timer_bcd #(.MAX_MIN_TENS(5)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .load(load),
    .load_min(load_min), .load_sec(load_sec), .start(start), .stop(stop),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running), .done(done), .expired(expired)
  );

`ifdef AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic [7:0] mn;
    logic [7:0] sc;
    logic       run;
    logic       dn;
    logic       exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen;

  // model: 0 idle, 1 run, 2 pause, 3 expired
  int m_state, m_secs, m_reload;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clampd(input int d, input int mx);
    return (d > mx) ? mx : d;
  endfunction

  function automatic int bcd2secs(input logic [7:0] mn, input logic [7:0] sc);
    int mt, mu, st, su;
    mt = clampd(int'(mn[7:4]), 5);
    mu = clampd(int'(mn[3:0]), 9);
    st = clampd(int'(sc[7:4]), 5);
    su = clampd(int'(sc[3:0]), 9);
    return (mt * 10 + mu) * 60 + st * 10 + su;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic step(input bit ld, input logic [7:0] lm, input logic [7:0] ls,
                      input bit st, input bit sp, input bit tk, input string tag);
    exp_t e;
    bit   dn;
    dn = 1'b0;
    load = ld; load_min = lm; load_sec = ls; start = st; stop = sp; tick_1hz = tk;
    if (ld) begin
      m_secs = bcd2secs(lm, ls); m_reload = m_secs; m_state = 0;
    end else begin
      case (m_state)
        0: if (!sp && st && m_secs != 0) m_state = 1;
        1: if (sp) m_state = 2;
           else if (tk) begin
             m_secs = m_secs - 1;
             if (m_secs == 0) begin
               dn = 1'b1;
               if (AUTO && m_reload != 0) m_secs = m_reload;
               else m_state = 3;
             end
           end
        2: if (!sp && st) m_state = 1;
        default: ;
      endcase
    end
    e.tag = tag; e.mn = to_bcd(m_secs / 60); e.sc = to_bcd(m_secs % 60);
    e.run = (m_state == 1); e.dn = dn; e.exp = (m_state == 3);
    sb.push_back(e);
    @(posedge clk); #1;
    load = 0; start = 0; stop = 0; tick_1hz = 0;
    e = sb.pop_front();
    check({e.tag, ".min"}, 32'(min_bcd), 32'(e.mn));
    check({e.tag, ".sec"}, 32'(sec_bcd), 32'(e.sc));
    check({e.tag, ".run"}, 32'(running), 32'(e.run));
    check({e.tag, ".done"}, 32'(done), 32'(e.dn));
    check({e.tag, ".exp"}, 32'(expired), 32'(e.exp));
    if (done === 1'b1) done_seen++;
  endtask

  task automatic do_load(input logic [7:0] lm, input logic [7:0] ls, input string tag);
    step(1, lm, ls, 0, 0, 0, tag);
  endtask
  task automatic do_start(input string tag); step(0, 8'h00, 8'h00, 1, 0, 0, tag); endtask
  task automatic do_stop(input string tag);  step(0, 8'h00, 8'h00, 0, 1, 0, tag); endtask
  task automatic do_tick(input string tag);
    step(0, 8'h00, 8'h00, 0, 0, 1, tag);
    step(0, 8'h00, 8'h00, 0, 0, 0, {tag, ".gap"});
  endtask

  initial begin
    reset = 1; tick_1hz = 0; load = 0; start = 0; stop = 0; load_min = 0; load_sec = 0;
    m_state = 0; m_secs = 0; m_reload = 0; done_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.min", 32'(min_bcd), 32'h00);
    check("rst.sec", 32'(sec_bcd), 32'h00);
    check("rst.flags", 32'({running, done, expired}), 32'h0);
    reset = 0;

    // 01:05 runs out after 65 ticks
    do_load(8'h01, 8'h05, "l0105");
    do_start("s0105");
    done_seen = 0;
    for (int unsigned i = 0; i < 65; i++) do_tick("t0105");
    check("t0105.done_once", 32'(done_seen), 32'd1);
    check("t0105.expired", 32'(expired), AUTO ? 32'd0 : 32'd1);
    check("t0105.count", 32'({min_bcd, sec_bcd}), AUTO ? 32'h0105 : 32'h0000);
    do_start("exp.start_ign");
    do_tick("exp.tick_ign");

    // multi-digit borrow
    do_load(8'h10, 8'h00, "l1000");
    do_start("s1000");
    step(0, 8'h00, 8'h00, 0, 0, 1, "t1000");
    check("t1000.count", 32'({min_bcd, sec_bcd}), 32'h0959);

    // clamping
    do_load(8'hAB, 8'h7C, "lclamp");
    check("lclamp.count", 32'({min_bcd, sec_bcd}), 32'h5959);
    do_start("sclamp");
    do_tick("tclamp");
    check("tclamp.count", 32'({min_bcd, sec_bcd}), 32'h5958);

    // pause freezes the count
    do_load(8'h00, 8'h10, "l0010");
    do_start("s0010");
    for (int unsigned i = 0; i < 3; i++) do_tick("t0010a");
    do_stop("p0010");
    for (int unsigned i = 0; i < 5; i++) do_tick("t0010p");
    check("p0010.frozen", 32'({min_bcd, sec_bcd}), 32'h0007);
    do_start("r0010");
    for (int unsigned i = 0; i < 6; i++) do_tick("t0010b");
    check("t0010.pre_exp", 32'(expired), 32'd0);
    do_tick("t0010last");
    check("t0010.exp7", 32'(expired), AUTO ? 32'd0 : 32'd1);

    // same-cycle priority
    do_load(8'h02, 8'h00, "l0200");
    do_start("s0200");
    step(0, 8'h00, 8'h00, 1, 1, 1, "startstop");
    check("startstop.paused", 32'(running), 32'd0);
    step(1, 8'h12, 8'h34, 1, 1, 1, "allthree");
    check("allthree.count", 32'({min_bcd, sec_bcd}), 32'h1234);
    check("allthree.run", 32'(running), 32'd0);
    step(0, 8'h00, 8'h00, 1, 0, 1, "idle_start_tick");

    // start with zero count is ignored
    do_load(8'h00, 8'h00, "l0000");
    do_start("s0000");

    // async reset mid-run
    do_load(8'h03, 8'h00, "l0300");
    do_start("s0300");
    do_tick("t0300");
    #2 reset = 1;
    #1;
    check("amid.count", 32'({min_bcd, sec_bcd}), 32'h0000);
    check("amid.flags", 32'({running, done, expired}), 32'h0);
    m_state = 0; m_secs = 0; m_reload = 0;
    @(posedge clk); #1;
    reset = 0;

    // short reload period
    do_load(8'h00, 8'h02, "l0002");
    do_start("s0002");
    done_seen = 0;
    for (int unsigned i = 0; i < 6; i++) do_tick("t0002");
    check("t0002.done_cnt", 32'(done_seen), AUTO ? 32'd3 : 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
